// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared constants and FSM state type for the data-memory access path
package dp_pkg;

    // Byte address to 64-bit word index shift
    localparam int WORD_SHIFT  = 3;

    // Defaults shared with the attached data memory
    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_MEMSIZE = 64;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter used for debug statistics
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count up on inc, holding at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LDUR/STUR load/store controller in front of the data memory
module mem_access_unit
    import dp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEMSIZE = DEF_MEMSIZE,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt,
    output logic [CNT_W-1:0]  fault_cnt
);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              addr_aligned;
    logic              addr_in_range;
    logic              req_legal;
    logic              in_access;
    logic              accept;

    // The range test uses the full-width index so huge addresses cannot alias into memory
    assign addr_aligned  = (req_addr[WORD_SHIFT-1:0] == '0);
    assign addr_in_range = ((req_addr >> WORD_SHIFT) < ADDR_W'(MEMSIZE));
    assign req_legal     = addr_aligned && addr_in_range;

    assign in_access = (state_q == ST_ACCESS);
    assign accept    = (state_q == ST_IDLE) && req_valid;

    // Next-state logic: latch the request, do one memory cycle, then hold the response
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (req_legal) begin
                        fault_d = 1'b0;
                        state_d = ST_ACCESS;
                    end else begin
                        // Illegal requests skip the memory entirely
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                rdata_d = wr_q ? '0 : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    fault_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    // Strobes live only in ACCESS and are mutually exclusive by construction
    assign mem_read  = in_access && !wr_q;
    assign mem_write = in_access &&  wr_q;
    assign mem_addr  = in_access ? (addr_q >> WORD_SHIFT) : '0;
    assign mem_wdata = mem_write ? wdata_q : '0;

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mem_read),
        .cnt (load_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mem_write),
        .cnt (store_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fault_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept && !req_legal),
        .cnt (fault_cnt)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit
module tb_mem_access_unit;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_ready = 1'b0;
    logic          fill = 1'b1;

    logic          req_ready, resp_valid, resp_fault, mem_write, mem_read;
    logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   load_cnt, store_cnt, fault_cnt;

    logic          s_req_ready, s_resp_valid, s_resp_fault, s_mem_write, s_mem_read;
    logic [DW-1:0] s_resp_rdata, s_mem_wdata;
    logic [AW-1:0] s_mem_addr;
    logic [1:0]    s_load_cnt, s_store_cnt, s_fault_cnt;

    mem_access_unit u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
    );

    // Narrow-counter build driven in lockstep with the main instance
    mem_access_unit #(.CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_rdata(s_resp_rdata),
        .resp_fault(s_resp_fault), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_write(s_mem_write), .mem_read(s_mem_read), .mem_rdata(mem_rdata),
        .load_cnt(s_load_cnt), .store_cnt(s_store_cnt), .fault_cnt(s_fault_cnt)
    );

    function automatic logic [DW-1:0] seed_word(input int i);
        return 64'(i) * 64'h9E37_79B9_7F4A_7C15 + 64'h0123_4567_89AB_CDEF;
    endfunction

    // Attached data memory: asynchronous read, write on clock edge
    logic [DW-1:0] mem [MS];
    assign mem_rdata = (mem_addr < 64'(MS)) ? mem[mem_addr[5:0]] : '0;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < MS; i++) mem[i] <= seed_word(i);
        end else if (mem_write && (mem_addr < 64'(MS))) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: word array, event counts, expected responses and expected memory accesses
    typedef struct packed { logic [63:0] rdata; logic fault; } resp_t;
    typedef struct packed { logic wr; logic [63:0] idx; logic [63:0] wdata; } acc_t;
    logic [DW-1:0] ref_mem [MS];
    resp_t exp_q[$];
    acc_t  acc_q[$];
    int n_load = 0, n_store = 0, n_fault = 0;

    function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] idx;
        idx = a / 8;
        if ((a % 8 != 0) || (idx >= 64'(MS))) begin
            n_fault++;
            exp_q.push_back('{rdata: 64'h0, fault: 1'b1});
        end else if (w) begin
            ref_mem[idx[5:0]] = d;
            n_store++;
            exp_q.push_back('{rdata: 64'h0, fault: 1'b0});
            acc_q.push_back('{wr: 1'b1, idx: idx, wdata: d});
        end else begin
            n_load++;
            exp_q.push_back('{rdata: ref_mem[idx[5:0]], fault: 1'b0});
            acc_q.push_back('{wr: 1'b0, idx: idx, wdata: 64'h0});
        end
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Monitor: checks strobes, response contents, latency and hold behaviour
    int    acc_edge = 0;
    int    lat_meas = -1;
    logic  prev_hold = 1'b0;
    logic [63:0] prev_rdata = '0;
    logic  prev_fault = 1'b0;
    always @(negedge clk) begin
        acc_t  a;
        resp_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("strobe_excl", 64'(mem_read & mem_write), 64'h0);
            chk("lockstep_ctl", {s_req_ready, s_resp_valid, s_resp_fault, s_mem_read, s_mem_write},
                {req_ready, resp_valid, resp_fault, mem_read, mem_write});
            chk("lockstep_data", s_resp_rdata ^ s_mem_wdata ^ s_mem_addr,
                resp_rdata ^ mem_wdata ^ mem_addr);
            if (mem_read || mem_write) begin
                if (acc_q.size() == 0) begin
                    chk("spurious_strobe", 64'h1, 64'h0);
                end else begin
                    a = acc_q.pop_front();
                    chk("strobe_dir", 64'(mem_write), 64'(a.wr));
                    chk("strobe_idx", mem_addr, a.idx);
                    if (a.wr) chk("strobe_wdata", mem_wdata, a.wdata);
                end
            end
            if (req_valid && req_ready) begin
                acc_edge = cyc + 1;
                lat_meas = -1;
            end
            if (resp_valid) begin
                chk("req_ready_in_resp", 64'(req_ready), 64'h0);
                if (lat_meas < 0) lat_meas = cyc - acc_edge;
                if (prev_hold) begin
                    chk("hold_rdata", resp_rdata, prev_rdata);
                    chk("hold_fault", 64'(resp_fault), 64'(prev_fault));
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_resp", 64'h1, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_fault", 64'(resp_fault), 64'(e.fault));
                        chk("resp_latency", 64'(lat_meas), e.fault ? 64'h0 : 64'h1);
                    end
                end
            end
            prev_hold  = resp_valid && !resp_ready;
            prev_rdata = resp_rdata;
            prev_fault = resp_fault;
        end
    end

    task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d);
        int t;
        model(w, a, d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("timeout_accept", 64'h1, 64'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input int hold);
        int t;
        resp_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        t = 0;
        while (!resp_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("timeout_resp", 64'h1, 64'h0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic chk_cnt();
        chk("load_cnt", load_cnt, 64'(n_load));
        chk("store_cnt", store_cnt, 64'(n_store));
        chk("fault_cnt", fault_cnt, 64'(n_fault));
        chk("sat_load_cnt", s_load_cnt, 64'(sat3(n_load)));
        chk("sat_store_cnt", s_store_cnt, 64'(sat3(n_store)));
        chk("sat_fault_cnt", s_fault_cnt, 64'(sat3(n_fault)));
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input int hold);
        send(w, a, d);
        drain(hold);
        chk_cnt();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
        chk({tag, "_resp_fault"}, 64'(resp_fault), 64'h0);
        chk({tag, "_strobes"}, {mem_read, mem_write}, 64'h0);
        chk({tag, "_mem_addr"}, mem_addr, 64'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
        chk({tag, "_counters"}, {load_cnt, store_cnt, fault_cnt}, 64'h0);
    endtask

    initial begin
        logic [63:0] a, d;
        int hs;
        for (int i = 0; i < MS; i++) ref_mem[i] = seed_word(i);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst  = 1'b0;
        fill = 1'b0;

        // Store then load the same word
        issue(1'b1, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 0);
        issue(1'b0, 64'h18, 64'h0, 1);
        // Misaligned load, two out-of-range stores, then word 0 must be untouched
        issue(1'b0, 64'h1C, 64'h0, 0);
        issue(1'b1, 64'h200, 64'h1111_2222_3333_4444, 0);
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5555_6666_7777_8888, 2);
        issue(1'b0, 64'h0, 64'h0, 0);
        issue(1'b0, 64'h1F8, 64'h0, 0);

        // Backpressure with the next request already waiting
        send(1'b0, 64'h18, 64'h0);
        model(1'b1, 64'h40, 64'hA5A5_5A5A_0F0F_F0F0);
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        req_valid = 1'b1;
        drain(5);
        hs = cyc;
        chk("idle_after_handshake", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        chk("second_accept_edge", 64'(acc_edge), 64'(hs + 1));
        req_valid = 1'b0;
        drain(0);
        chk_cnt();

        // Reset while a store is in its memory cycle
        send(1'b1, 64'h28, 64'h0BAD_F00D_1234_5678);
        chk("rst_access_write", 64'(mem_write), 64'h1);
        chk("rst_access_addr", mem_addr, 64'h5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        n_load = 0;
        n_store = 0;
        n_fault = 0;
        chk_reset_state("midrst");
        issue(1'b0, 64'h28, 64'h0, 0);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                7:       a = (64'($urandom_range(0, 63)) << 3) | 64'($urandom_range(1, 7));
                8:       a = 64'(MS * 8) + (64'($urandom_range(0, 1000)) << 3);
                9:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 63)) << 3;
            endcase
            d = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_empty", 64'(exp_q.size()), 64'h0);
        chk("strobe_queue_empty", 64'(acc_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
